clarvi_muldiv_ctrl: RTL and testbench

Iterative RV64M multiply/divide sequencer sitting beside the single-cycle execute ALU in the Clarvi pipeline. It accepts one M-extension operation per handshake, runs a radix-2 shift-add multiply or restoring divide over multiple cycles, and returns a 64-bit result through a valid/ready handshake. While it is busy, the pipeline stalls on start_ready low. A flush aborts the operation in progress.

---
 rtl/clarvi_muldiv_ctrl_if.sv | 25 ++
 rtl/clarvi_muldiv_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_clarvi_muldiv_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clarvi_muldiv_ctrl_if.sv
// Handshake bundle between the Clarvi execute stage and the iterative mul/div unit.
// The pipeline side is the master; the unit itself is the slave.
interface clarvi_muldiv_ctrl_if;
  logic        start_valid;
  logic        start_ready;
  logic [2:0]  op;
  logic        is32_bit_op;
  logic [63:0] rs1_value;
  logic [63:0] rs2_value;
  logic        flush;
  logic        result_valid;
  logic        result_ready;
  logic [63:0] result;
  logic        busy;

  modport master (
    output start_valid, op, is32_bit_op, rs1_value, rs2_value, flush, result_ready,
    input  start_ready, result_valid, result, busy
  );

  modport slave (
    input  start_valid, op, is32_bit_op, rs1_value, rs2_value, flush, result_ready,
    output start_ready, result_valid, result, busy
  );
endinterface

// File: rtl/clarvi_muldiv_ctrl.sv
// Iterative RV64M sequencer: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up in a dedicated final step.
module clarvi_muldiv_ctrl #(
  parameter bit EARLY_OUT = 1'b1
) (
  input logic                 clock,
  input logic                 reset,
  clarvi_muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  state_e       state_q;
  logic [5:0]   count_q;
  logic [2:0]   op_q;
  logic         w_q;
  logic         neg_a_q;
  logic         neg_b_q;
  logic         zero_q;
  logic         early_q;
  // Multiply: acc = product, opa = shifted multiplicand, opb = multiplier.
  // Divide: acc[63:0] = remainder, opa[63:0] = divisor, opb = dividend/quotient.
  logic [127:0] acc_q;
  logic [127:0] opa_q;
  logic [63:0]  opb_q;
  logic [63:0]  result_q;
  logic         result_valid_q;
  logic         busy_q;

  // Operand preparation from the live request.
  logic        is_div;
  logic        sgn_a;
  logic        sgn_b;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] a_abs;
  logic [63:0] b_abs;
  logic        b_zero;
  logic        ovf;
  logic        early;
  logic [63:0] early_raw;
  logic [63:0] early_res;

  always_comb begin
    is_div = bus.op[2];
    sgn_a  = is_div ? ~bus.op[0] : (bus.op == 3'd1 || bus.op == 3'd2);
    sgn_b  = is_div ? ~bus.op[0] : (bus.op == 3'd1);
    if (bus.is32_bit_op) begin
      a_ext = {{32{sgn_a & bus.rs1_value[31]}}, bus.rs1_value[31:0]};
      b_ext = {{32{sgn_b & bus.rs2_value[31]}}, bus.rs2_value[31:0]};
    end else begin
      a_ext = bus.rs1_value;
      b_ext = bus.rs2_value;
    end
    a_neg  = sgn_a & a_ext[63];
    b_neg  = sgn_b & b_ext[63];
    a_abs  = a_neg ? (64'd0 - a_ext) : a_ext;
    b_abs  = b_neg ? (64'd0 - b_ext) : b_ext;
    b_zero = (b_ext == 64'd0);
    ovf    = is_div && sgn_a && (b_ext == {64{1'b1}}) &&
             (a_ext == (bus.is32_bit_op ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    early  = EARLY_OUT && is_div && (b_zero || ovf);
    if (b_zero) begin
      early_raw = bus.op[1] ? a_ext : {64{1'b1}};
    end else begin
      early_raw = bus.op[1] ? 64'd0 : a_ext;
    end
    early_res = bus.is32_bit_op ? {{32{early_raw[31]}}, early_raw[31:0]} : early_raw;
  end

  // One iteration step for each algorithm.
  logic [127:0] mul_acc_nx;
  logic [64:0]  div_sh;
  logic         div_borrow;
  logic [63:0]  div_diff;
  logic [63:0]  div_rem_nx;

  always_comb begin
    mul_acc_nx = opb_q[0] ? (acc_q + opa_q) : acc_q;
    div_sh     = {acc_q[63:0], opb_q[63]};
    div_borrow = div_sh < {1'b0, opa_q[63:0]};
    div_diff   = div_sh[63:0] - opa_q[63:0];
    div_rem_nx = div_borrow ? div_sh[63:0] : div_diff;
  end

  // Sign fix-up and result selection.
  logic [127:0] prod;
  logic [63:0]  mul_raw;
  logic [63:0]  quo_f;
  logic [63:0]  rem_f;
  logic [63:0]  raw;
  logic [63:0]  fix_res;

  always_comb begin
    prod    = (neg_a_q ^ neg_b_q) ? (128'd0 - acc_q) : acc_q;
    mul_raw = (op_q[1:0] == 2'd0) ? prod[63:0] : prod[127:64];
    // A zero divisor has no sign, so the all-ones quotient is never negated.
    quo_f   = ((neg_a_q ^ neg_b_q) && !zero_q) ? (64'd0 - opb_q) : opb_q;
    rem_f   = neg_a_q ? (64'd0 - acc_q[63:0]) : acc_q[63:0];
    raw     = op_q[2] ? (op_q[1] ? rem_f : quo_f) : mul_raw;
    if (early_q) begin
      fix_res = acc_q[63:0];
    end else begin
      fix_res = w_q ? {{32{raw[31]}}, raw[31:0]} : raw;
    end
  end

  logic last_iter;
  assign last_iter = (count_q == (w_q ? 6'd31 : 6'd63));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      count_q        <= 6'd0;
      op_q           <= 3'd0;
      w_q            <= 1'b0;
      neg_a_q        <= 1'b0;
      neg_b_q        <= 1'b0;
      zero_q         <= 1'b0;
      early_q        <= 1'b0;
      acc_q          <= 128'd0;
      opa_q          <= 128'd0;
      opb_q          <= 64'd0;
      result_q       <= 64'd0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else if (bus.flush) begin
      state_q        <= StIdle;
      count_q        <= 6'd0;
      result_q       <= 64'd0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_valid) begin
            op_q    <= bus.op;
            w_q     <= bus.is32_bit_op;
            neg_a_q <= a_neg;
            neg_b_q <= b_neg;
            zero_q  <= b_zero;
            early_q <= early;
            count_q <= 6'd0;
            busy_q  <= 1'b1;
            if (early) begin
              acc_q   <= {64'd0, early_res};
              state_q <= StFix;
            end else if (is_div) begin
              acc_q   <= 128'd0;
              opa_q   <= {64'd0, b_abs};
              // W dividends sit in the top half so 32 shifts consume them fully.
              opb_q   <= bus.is32_bit_op ? {a_abs[31:0], 32'd0} : a_abs;
              state_q <= StBusy;
            end else begin
              acc_q   <= 128'd0;
              opa_q   <= {64'd0, a_abs};
              opb_q   <= b_abs;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (op_q[2]) begin
            acc_q <= {64'd0, div_rem_nx};
            opb_q <= {opb_q[62:0], ~div_borrow};
          end else begin
            acc_q <= mul_acc_nx;
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
          end
          if (last_iter) begin
            count_q <= 6'd0;
            state_q <= StFix;
          end else begin
            count_q <= count_q + 6'd1;
          end
        end
        StFix: begin
          result_q       <= fix_res;
          result_valid_q <= 1'b1;
          state_q        <= StDone;
        end
        StDone: begin
          if (bus.result_ready) begin
            result_q       <= 64'd0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.start_ready  = (state_q == StIdle) && !bus.flush;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_clarvi_muldiv_ctrl.sv
// Bench for clarvi_muldiv_ctrl: one instance per EARLY_OUT value, an arithmetic
// reference model checked every cycle, and directed vectors with literal results.
module tb_clarvi_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sv = 2'b00;
  logic [1:0]  rr = 2'b00;
  logic [2:0]  op = 3'd0;
  logic        w = 1'b0;
  logic [63:0] rs1 = 64'd0;
  logic [63:0] rs2 = 64'd0;
  logic        flush = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  clarvi_muldiv_ctrl_if bus0 ();
  clarvi_muldiv_ctrl_if bus1 ();

  assign bus0.start_valid  = sv[0];
  assign bus0.result_ready = rr[0];
  assign bus0.op           = op;
  assign bus0.is32_bit_op  = w;
  assign bus0.rs1_value    = rs1;
  assign bus0.rs2_value    = rs2;
  assign bus0.flush        = flush;
  assign bus1.start_valid  = sv[1];
  assign bus1.result_ready = rr[1];
  assign bus1.op           = op;
  assign bus1.is32_bit_op  = w;
  assign bus1.rs1_value    = rs1;
  assign bus1.rs2_value    = rs2;
  assign bus1.flush        = flush;

  clarvi_muldiv_ctrl #(.EARLY_OUT(1'b0)) u_full (.clock(clock), .reset(reset), .bus(bus0));
  clarvi_muldiv_ctrl #(.EARLY_OUT(1'b1)) u_early (.clock(clock), .reset(reset), .bus(bus1));

  function automatic logic [63:0] ref_result(logic [2:0] o, logic ww, logic [63:0] a,
                                             logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  a32;
    logic [31:0]  b32;
    logic [31:0]  r32;
    logic [63:0]  r;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = 32'd0;
    r   = 64'd0;
    if (ww) begin
      case (o)
        3'd0: r32 = a32 * b32;
        3'd4: begin
          if (b32 == 32'd0) r32 = 32'hFFFF_FFFF;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
          else r32 = $signed(a32) / $signed(b32);
        end
        3'd5: begin
          if (b32 == 32'd0) r32 = 32'hFFFF_FFFF;
          else r32 = a32 / b32;
        end
        3'd6: begin
          if (b32 == 32'd0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = 32'd0;
          else r32 = $signed(a32) % $signed(b32);
        end
        3'd7: begin
          if (b32 == 32'd0) r32 = a32;
          else r32 = a32 % b32;
        end
        default: r32 = 32'd0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (o)
        3'd0: r = a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
        3'd4: begin
          if (b == 64'd0) r = {64{1'b1}};
          else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r = a;
          else r = $signed(a) / $signed(b);
        end
        3'd5: begin
          if (b == 64'd0) r = {64{1'b1}};
          else r = a / b;
        end
        3'd6: begin
          if (b == 64'd0) r = a;
          else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r = 64'd0;
          else r = $signed(a) % $signed(b);
        end
        default: begin
          if (b == 64'd0) r = a;
          else r = a % b;
        end
      endcase
    end
    return r;
  endfunction

  function automatic bit is_special(logic [2:0] o, logic ww, logic [63:0] a, logic [63:0] b);
    bit zero;
    bit ovf;
    zero = ww ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = !o[0] && (ww ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}));
    return o[2] && (zero || ovf);
  endfunction

  // Reference model: per instance, a pending op with a cycle countdown and a held result.
  logic        m_pend[2];
  logic        m_valid[2];
  int          m_rem[2];
  logic [63:0] m_res[2];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_pend[d]  <= 1'b0;
        m_valid[d] <= 1'b0;
        m_rem[d]   <= 0;
        m_res[d]   <= 64'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (flush) begin
          m_pend[d]  <= 1'b0;
          m_valid[d] <= 1'b0;
        end else if (m_valid[d]) begin
          if (rr[d]) m_valid[d] <= 1'b0;
        end else if (m_pend[d]) begin
          if (m_rem[d] == 0) begin
            m_pend[d]  <= 1'b0;
            m_valid[d] <= 1'b1;
          end else begin
            m_rem[d] <= m_rem[d] - 1;
          end
        end else if (sv[d]) begin
          m_pend[d] <= 1'b1;
          m_res[d]  <= ref_result(op, w, rs1, rs2);
          m_rem[d]  <= (d == 1 && is_special(op, w, rs1, rs2)) ? 0 : (w ? 32 : 64);
        end
      end
    end
  end

  function automatic logic get_valid(int d);
    return (d == 1) ? bus1.result_valid : bus0.result_valid;
  endfunction
  function automatic logic get_ready(int d);
    return (d == 1) ? bus1.start_ready : bus0.start_ready;
  endfunction
  function automatic logic get_busy(int d);
    return (d == 1) ? bus1.busy : bus0.busy;
  endfunction
  function automatic logic [63:0] get_result(int d);
    return (d == 1) ? bus1.result : bus0.result;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        logic        ev;
        logic        eb;
        logic        er;
        logic [63:0] eres;
        ev   = m_valid[d];
        eb   = m_pend[d] || m_valid[d];
        er   = !eb && !flush;
        eres = m_valid[d] ? m_res[d] : 64'd0;
        checks++;
        if (get_valid(d) !== ev || get_busy(d) !== eb || get_ready(d) !== er ||
            get_result(d) !== eres) begin
          failures++;
          $display("FAIL cycle_dut%0d @%0d: got valid=%b busy=%b ready=%b result=%h, want valid=%b busy=%b ready=%b result=%h",
                   d, cyc, get_valid(d), get_busy(d), get_ready(d), get_result(d),
                   ev, eb, er, eres);
        end
      end
    end
  end

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic start(input int d, input logic [2:0] o, input logic ww, input logic [63:0] a,
                       input logic [63:0] b, output int t0);
    op  = o;
    w   = ww;
    rs1 = a;
    rs2 = b;
    sv[d] = 1'b1;
    @(posedge clock);
    #1;
    sv[d] = 1'b0;
    t0  = cyc;
    rs1 = {$urandom, $urandom};
    rs2 = {$urandom, $urandom};
  endtask

  task automatic wait_valid(input int d, input int t0, input logic [63:0] lit, input int lat,
                            input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (get_valid(d)) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: result_valid never rose, wanted after %0d cycles", name, lat);
    end else begin
      check64({name, "_latency"}, 64'(cyc - t0), 64'(lat));
      check64({name, "_result"}, get_result(d), lit);
    end
  endtask

  task automatic take(input int d);
    rr[d] = 1'b1;
    @(posedge clock);
    #1;
    rr[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic [2:0] o, input logic ww, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] lit, input int lat,
                     input string name);
    int t0;
    check64({name, "_model"}, ref_result(o, ww, a, b), lit);
    start(d, o, ww, a, b, t0);
    wait_valid(d, t0, lit, lat, name);
    take(d);
  endtask

  localparam logic [63:0] Ones = {64{1'b1}};
  localparam logic [63:0] MinS = 64'h8000_0000_0000_0000;

  initial begin
    int t0;
    int seen;
    #2;
    check64("reset_valid", {63'd0, bus0.result_valid}, 64'd0);
    check64("reset_result", bus0.result, 64'd0);
    check64("reset_busy", {63'd0, bus1.busy}, 64'd0);
    #20;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check64("post_reset_ready", {62'd0, bus1.start_ready, bus0.start_ready}, 64'd3);

    run(0, 3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65, "mul");
    run(0, 3'd3, 1'b0, Ones, Ones, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu");
    run(0, 3'd2, 1'b0, Ones, 64'd2, Ones, 65, "mulhsu");
    run(0, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, Ones, 65, "mulh");
    run(0, 3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw");
    run(0, 3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw");
    run(0, 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, Ones, 33, "remw");
    run(0, 3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd1, 64'hFFFF_FFFF_FFFF_FFF0, 33, "divuw");
    run(0, 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, "divu");
    run(0, 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, Ones, 65, "rem_neg");
    run(0, 3'd4, 1'b0, 64'h55, 64'd0, Ones, 65, "div0_full");
    run(0, 3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 65, "remu0_full");
    run(0, 3'd4, 1'b0, MinS, Ones, MinS, 65, "divovf_full");
    run(0, 3'd6, 1'b0, MinS, Ones, 64'd0, 65, "removf_full");

    run(1, 3'd4, 1'b0, 64'h55, 64'd0, Ones, 1, "div0_early");
    run(1, 3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, "remu0_early");
    run(1, 3'd4, 1'b0, MinS, Ones, MinS, 1, "divovf_early");
    run(1, 3'd6, 1'b0, MinS, Ones, 64'd0, 1, "removf_early");
    run(1, 3'd7, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1, "remuw0_early");
    run(1, 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1,
        "divwovf_early");
    run(1, 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, "divu_early_inst");

    // Backpressure in DONE, then an immediate follow-on start.
    start(0, 3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, t0);
    wait_valid(0, t0, 64'hFFFF_FFFF_FFFF_FFFD, 33, "bp");
    repeat (5) begin
      @(negedge clock);
      check64("bp_hold_result", bus0.result, 64'hFFFF_FFFF_FFFF_FFFD);
      check64("bp_hold_flags", {62'd0, bus0.result_valid, bus0.start_ready}, 64'd2);
    end
    take(0);
    op  = 3'd5;
    w   = 1'b0;
    rs1 = 64'd100;
    rs2 = 64'd7;
    sv[0] = 1'b1;
    @(negedge clock);
    check64("bp_ready_after", {63'd0, bus0.start_ready}, 64'd1);
    @(posedge clock);
    #1;
    sv[0] = 1'b0;
    t0 = cyc;
    @(negedge clock);
    check64("bp_next_accepted", {63'd0, bus0.busy}, 64'd1);
    wait_valid(0, t0, 64'd14, 65, "bp_next");
    take(0);

    // Flush at iteration 20.
    start(0, 3'd4, 1'b0, 64'd1000, 64'd3, t0);
    repeat (20) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    check64("flush_busy", {63'd0, bus0.busy}, 64'd0);
    seen = 0;
    repeat (80) begin
      @(negedge clock);
      if (bus0.result_valid) seen++;
    end
    check64("flush_no_result", 64'(seen), 64'd0);

    // Flush beats a simultaneous start.
    op  = 3'd0;
    rs1 = 64'd5;
    rs2 = 64'd6;
    flush = 1'b1;
    sv[0] = 1'b1;
    @(negedge clock);
    check64("flush_start_ready", {63'd0, bus0.start_ready}, 64'd0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    sv[0] = 1'b0;
    @(negedge clock);
    check64("flush_start_idle", {63'd0, bus0.busy}, 64'd0);

    // Asynchronous reset mid-operation.
    start(0, 3'd0, 1'b0, 64'd7, 64'd9, t0);
    repeat (10) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check64("areset_busy", {63'd0, bus0.busy}, 64'd0);
    check64("areset_result", bus0.result, 64'd0);
    check64("areset_valid", {63'd0, bus0.result_valid}, 64'd0);
    #8;
    reset = 1'b0;
    @(posedge clock);
    #1;
    run(0, 3'd7, 1'b1, 64'd23, 64'd5, 64'd3, 33, "after_reset");

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time, failures so far %0d", failures);
    $fatal(1, "watchdog");
  end

endmodule
